// File: rtl/loader_pkg.sv
// Shared types and sizing helpers for the instruction-memory loader.
package loader_pkg;

    // Loader FSM states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } loader_state_t;

    // Debug view of the loader: FSM state plus the packer's current byte lane.
    typedef struct packed {
        loader_state_t state;
        logic [1:0]    lane;
    } loader_dbg_t;

    localparam int BYTES_PER_WORD = 4;

    // Number of 32-bit words that fit in a byte-addressed memory of addr_w bits.
    function automatic int max_words(input int addr_w);
        return (1 << addr_w) / BYTES_PER_WORD;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Little-endian packer: collects four stream bytes into one 32-bit word.
// 'word' is a look-ahead view: while 'push' is high it already contains
// byte_in in the current lane, so the owner can capture the finished word on
// the same edge that accepts the fourth byte.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic [1:0]  lane,
    output logic        full
);

    logic [31:0] held;

    // Merge the incoming byte into its lane (byte k -> bits [8k+7:8k]).
    always_comb begin
        word = held;
        if (push) begin
            word[{lane, 3'b000} +: 8] = byte_in;
        end
    end

    // Three bytes held: the next push completes the word.
    assign full = (lane == 2'd3);

    // Byte storage and lane pointer; clear wins over push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held <= '0;
            lane <= 2'd0;
        end else if (clear) begin
            held <= '0;
            lane <= 2'd0;
        end else if (push) begin
            held <= word;
            lane <= lane + 2'd1;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: takes a byte stream (16-bit little-endian word
// count followed by little-endian 32-bit words), writes the words to
// consecutive word addresses and holds the CPU until the image is complete.
//
// Handshake: a byte moves when byte_valid & byte_ready are both high at a
// rising clock edge; the source keeps byte_data stable while byte_ready is low.
// byte_ready is registered and only high in LEN_LO, LEN_HI and DATA.
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    output logic                     byte_ready,
    output logic                     wr_en,
    output logic [ADDRESS_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     cpu_hold,
    output logic                     done,
    output logic                     error,
    output loader_dbg_t              dbg
);

    localparam int          MAX_WORDS = max_words(ADDRESS_WIDTH);
    localparam logic [15:0] MAX_LEN   = 16'(MAX_WORDS);
    localparam int          IDX_W     = ADDRESS_WIDTH - 2;

    loader_state_t state;
    logic [15:0]   len;
    logic [15:0]   word_idx;

    logic          xfer;
    logic [15:0]   len_full;
    logic [15:0]   idx_next;
    logic          idle_like;

    logic          pk_clear;
    logic          pk_push;
    logic [31:0]   pk_word;
    logic [1:0]    pk_lane;
    logic          pk_full;

    assign xfer      = byte_valid & byte_ready;
    assign len_full  = {byte_data, len[7:0]};
    assign idx_next  = word_idx + 16'd1;
    assign idle_like = (state == IDLE) || (state == DONE) || (state == ERR);

    // The packer restarts at lane 0 for every new image and after every write.
    assign pk_clear = (idle_like && start) || (state == WRITE);
    assign pk_push  = (state == DATA) && xfer;

    byte_packer u_packer (
        .clk     (clk),
        .rst     (rst),
        .clear   (pk_clear),
        .push    (pk_push),
        .byte_in (byte_data),
        .word    (pk_word),
        .lane    (pk_lane),
        .full    (pk_full)
    );

    assign dbg.state = state;
    assign dbg.lane  = pk_lane;

    // Loader FSM with registered outputs, length register and word counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            len        <= '0;
            word_idx   <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state      <= LEN_LO;
                        byte_ready <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        cpu_hold   <= 1'b1;
                        len        <= '0;
                        word_idx   <= '0;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        len[7:0] <= byte_data;
                        state    <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len <= len_full;
                        if (len_full == 16'd0) begin
                            state      <= DONE;
                            byte_ready <= 1'b0;
                            done       <= 1'b1;
                            cpu_hold   <= 1'b0;
                        end else if (len_full > MAX_LEN) begin
                            state      <= ERR;
                            byte_ready <= 1'b0;
                            error      <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    // Fourth byte: capture address and finished word for WRITE.
                    if (xfer && pk_full) begin
                        state      <= WRITE;
                        byte_ready <= 1'b0;
                        wr_en      <= 1'b1;
                        wr_addr    <= {word_idx[IDX_W-1:0], 2'b00};
                        wr_data    <= pk_word;
                    end
                end
                WRITE: begin
                    wr_en    <= 1'b0;
                    word_idx <= idx_next;
                    if (idx_next == len) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state      <= DATA;
                        byte_ready <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    byte_ready <= 1'b0;
                    wr_en      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Testbench for instr_mem_loader: directed and randomized image loads checked
// against a word-level model of what memory writes and final status to expect.
module tb_instr_mem_loader;
    import loader_pkg::*;

    localparam int AW   = 8;
    localparam int MAXW = (1 << AW) / 4;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;
    loader_dbg_t dbg;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    instr_mem_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .dbg        (dbg)
    );

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;
    bit aborted = 1'b0;

    logic [39:0] exp_q[$];   // {addr, data} of expected writes, in order
    int          lat_q[$];   // cycle at which each write must be visible
    logic [31:0] words_q[$]; // payload words of the image being loaded
    int          writes_seen = 0;
    logic [39:0] mon_e;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every wr_en cycle must match the next expected write.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            writes_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(wr_addr), 64'hFFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(mon_e[39:32]));
                check("wr_data", 64'(wr_data), 64'(mon_e[31:0]));
            end
            if (lat_q.size() == 0) check("wr_latency_missing", 64'(cyc), 64'hFFFF);
            else                   check("wr_latency", 64'(cyc), 64'(lat_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b, input int max_gap, input bit word_end,
                             input bit rand_start);
        int gap;
        int budget;
        if (aborted) return;
        gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
        repeat (gap) begin
            @(negedge clk);
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
        end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        start      = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
        budget     = 0;
        while (byte_ready !== 1'b1 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (byte_ready !== 1'b1) begin
            check("ready_timeout", 64'(byte_ready), 64'd1);
            aborted    = 1'b1;
            byte_valid = 1'b0;
            start      = 1'b0;
            return;
        end
        if (word_end) lat_q.push_back(cyc + 1);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic fill_random(input int n);
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back($urandom);
    endtask

    // One image load; expectations come from the word list and the length rules.
    task automatic run_load(input int len, input int max_gap, input bit do_start,
                            input bit rand_start);
        bit          legal;
        int          budget;
        int          seen0;
        logic [15:0] l16;
        logic [31:0] w;
        l16   = 16'(len);
        legal = (len <= MAXW);
        seen0 = writes_seen;
        if (do_start) pulse_start();
        if (legal) begin
            for (int i = 0; i < len; i++) exp_q.push_back({8'(i * 4), words_q[i]});
        end
        send_byte(l16[7:0], max_gap, 1'b0, rand_start);
        send_byte(l16[15:8], max_gap, 1'b0, rand_start);
        if (legal) begin
            for (int i = 0; i < len; i++) begin
                w = words_q[i];
                for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], max_gap, k == 3, rand_start);
            end
        end
        @(negedge clk);
        byte_valid = 1'b0;
        budget = 0;
        while (done !== 1'b1 && error !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check("done", 64'(done), 64'(legal));
        check("error", 64'(error), 64'(!legal));
        check("cpu_hold", 64'(cpu_hold), 64'(!legal));
        check("ready_after_load", 64'(byte_ready), 64'd0);
        check("pending_writes", 64'(exp_q.size()), 64'd0);
        check("write_count", 64'(writes_seen - seen0), legal ? 64'(len) : 64'd0);
        if (legal && len > 0) begin
            check("last_wr_addr", 64'(wr_addr), 64'((len - 1) * 4));
            check("last_wr_data", 64'(wr_data), 64'(words_q[len - 1]));
        end
        exp_q.delete();
        lat_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int seen0;
        int len;
        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b1;
        byte_data  = 8'hA5;

        // Reset state with a byte offered.
        @(negedge clk);
        check("rst_byte_ready", 64'(byte_ready), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_cpu_hold", 64'(cpu_hold), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_ignores_valid", 64'(byte_ready), 64'd0);
        byte_valid = 1'b0;

        // Two-word directed image.
        words_q.delete();
        words_q.push_back(32'h0000_0013);
        words_q.push_back(32'h0010_0093);
        run_load(2, 0, 1'b1, 1'b0);

        // Empty image.
        run_load(0, 0, 1'b1, 1'b0);

        // Oversize image, then recovery.
        seen0 = writes_seen;
        run_load(MAXW + 1, 0, 1'b1, 1'b0);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = 8'h5A;
        repeat (4) @(negedge clk);
        check("err_ready", 64'(byte_ready), 64'd0);
        check("err_hold", 64'(error), 64'd1);
        check("err_no_writes", 64'(writes_seen - seen0), 64'd0);
        byte_valid = 1'b0;
        pulse_start();
        check("recover_state", 64'(dbg.state), 64'(LEN_LO));
        check("recover_ready", 64'(byte_ready), 64'd1);
        check("recover_error", 64'(error), 64'd0);
        check("recover_cpu_hold", 64'(cpu_hold), 64'd1);
        fill_random(3);
        run_load(3, 1, 1'b0, 1'b0);

        // Full-size image with random gaps.
        fill_random(MAXW);
        run_load(MAXW, 3, 1'b1, 1'b0);

        // Reset after two data bytes, then a clean one-word reload.
        pulse_start();
        send_byte(8'h01, 0, 1'b0, 1'b0);
        send_byte(8'h00, 0, 1'b0, 1'b0);
        send_byte(8'hAA, 0, 1'b0, 1'b0);
        send_byte(8'hBB, 0, 1'b0, 1'b0);
        @(negedge clk);
        byte_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_ready", 64'(byte_ready), 64'd0);
        check("midrst_cpu_hold", 64'(cpu_hold), 64'd1);
        check("midrst_lane", 64'(dbg.lane), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        fill_random(1);
        run_load(1, 0, 1'b1, 1'b0);

        // Randomized loads, including empty and oversize lengths and stray starts.
        for (int it = 0; it < 8; it++) begin
            case ($urandom_range(0, 5))
                0:       len = 0;
                1:       len = $urandom_range(MAXW + 1, 400);
                default: len = $urandom_range(1, 9);
            endcase
            fill_random((len <= MAXW) ? len : 0);
            run_load(len, $urandom_range(0, 3), 1'b1, 1'b1);
        end

        check("final_exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit.
    initial begin
        #900000;
        fails++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
